// File: rtl/full_adder_pkg.sv
// Shared constants for the registered full-adder slice.
package full_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 1;

endpackage

// File: rtl/full_adder_fa_cell.sv
// One-bit combinational full-adder cell; the ripple element of full_adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {c,s} = x + y + z, one clock of latency.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             z,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_w;

    assign carry[0] = z;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fa_cell u_cell (
            .a    (x[i]),
            .b    (y[i]),
            .cin  (carry[i]),
            .sum  (sum_w[i]),
            .cout (carry[i+1])
        );
    end

    // Result registers only load on a qualified input; otherwise they hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s         <= '0;
            c         <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s <= sum_w;
                c <= carry[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder at widths 1, 4 and 8: arithmetic model plus directed literal checks.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst_n;

    logic       x1, y1, z1, v1;
    logic       s1, c1, ov1;
    logic [3:0] x4, y4, s4;
    logic       z4, v4, c4, ov4;
    logic [7:0] x8, y8, s8;
    logic       z8, v8, c8, ov8;

    int vectors = 0;
    int miscompares = 0;

    full_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .x(x1), .y(y1), .z(z1), .in_valid(v1),
        .s(s1), .c(c1), .out_valid(ov1)
    );
    full_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .x(x4), .y(y4), .z(z4), .in_valid(v4),
        .s(s4), .c(c4), .out_valid(ov4)
    );
    full_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .x(x8), .y(y8), .z(z8), .in_valid(v8),
        .s(s8), .c(c8), .out_valid(ov8)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: the registered result is the plain integer sum of the last valid inputs.
    logic [1:0] exp1;
    logic [4:0] exp4;
    logic [8:0] exp8;
    logic       eov1, eov4, eov8;
    logic       known = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            known <= 1'b1;
            exp1 <= '0; exp4 <= '0; exp8 <= '0;
            eov1 <= 1'b0; eov4 <= 1'b0; eov8 <= 1'b0;
        end else begin
            eov1 <= v1; eov4 <= v4; eov8 <= v8;
            if (v1) exp1 <= 2'(x1) + 2'(y1) + 2'(z1);
            if (v4) exp4 <= 5'(x4) + 5'(y4) + 5'(z4);
            if (v8) exp8 <= 9'(x8) + 9'(y8) + 9'(z8);
        end
    end

    always @(negedge clk) begin
        if (known) begin
            check("model_w1_sum", 9'({c1, s1}), 9'(exp1));
            check("model_w1_valid", 9'(ov1), 9'(eov1));
            check("model_w4_sum", 9'({c4, s4}), 9'(exp4));
            check("model_w4_valid", 9'(ov4), 9'(eov4));
            check("model_w8_sum", 9'({c8, s8}), 9'(exp8));
            check("model_w8_valid", 9'(ov8), 9'(eov8));
        end
    end

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic es, input logic ec, input logic ev);
        check({name, "_s"}, 9'(s1), 9'(es));
        check({name, "_c"}, 9'(c1), 9'(ec));
        check({name, "_valid"}, 9'(ov1), 9'(ev));
    endtask

    logic [7:0] tt_s = 8'b1001_0110;
    logic [7:0] tt_c = 8'b1110_1000;
    logic [2:0] combo;

    initial begin
        rst_n = 1'b0;
        x1 = 1'b1; y1 = 1'b1; z1 = 1'b1; v1 = 1'b1;
        x4 = 4'hF; y4 = 4'hF; z4 = 1'b1; v4 = 1'b1;
        x8 = 8'hFF; y8 = 8'hFF; z8 = 1'b1; v8 = 1'b1;

        for (int i = 0; i < 3; i++) begin
            next_cycle();
            chk1("reset_w1", 1'b0, 1'b0, 1'b0);
            check("reset_w8", 9'({c8, s8, ov8} >> 1), 9'd0);
        end

        rst_n = 1'b1;
        v4 = 1'b0; v8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            {x1, y1, z1} = combo;
            v1 = 1'b1;
            next_cycle();
            chk1("truth_table", tt_s[i], tt_c[i], 1'b1);
        end

        {x1, y1, z1} = 3'b100; v1 = 1'b1;
        next_cycle();
        chk1("hold_load", 1'b1, 1'b0, 1'b1);
        {x1, y1, z1} = 3'b111; v1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            chk1("hold", 1'b1, 1'b0, 1'b0);
        end

        {x1, y1, z1} = 3'b111; v1 = 1'b1;
        next_cycle();
        chk1("stream_111", 1'b1, 1'b1, 1'b1);
        rst_n = 1'b0;
        {x1, y1, z1} = 3'b011;
        next_cycle();
        chk1("mid_reset", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        next_cycle();
        chk1("after_reset_011", 1'b0, 1'b1, 1'b1);
        v1 = 1'b0;

        x4 = 4'hF; y4 = 4'h1; z4 = 1'b0; v4 = 1'b1;
        next_cycle();
        check("w4_f_plus_1", 9'({c4, s4}), 9'h010);
        x4 = 4'h7; y4 = 4'h8; z4 = 1'b1;
        next_cycle();
        check("w4_7_plus_8_plus_1", 9'({c4, s4}), 9'h010);
        x4 = 4'h5; y4 = 4'h2; z4 = 1'b1;
        next_cycle();
        check("w4_5_plus_2_plus_1", 9'({c4, s4}), 9'h008);
        check("w4_valid", 9'(ov4), 9'd1);

        x8 = 8'hFF; y8 = 8'h00; z8 = 1'b1; v8 = 1'b1;
        next_cycle();
        check("w8_ff_plus_carry", 9'({c8, s8}), 9'h100);

        for (int i = 0; i < 1000; i++) begin
            x1 = 1'($urandom); y1 = 1'($urandom); z1 = 1'($urandom); v1 = 1'($urandom);
            x4 = 4'($urandom); y4 = 4'($urandom); z4 = 1'($urandom); v4 = 1'($urandom);
            x8 = 8'($urandom); y8 = 8'($urandom); z8 = 1'($urandom); v8 = 1'($urandom);
            next_cycle();
        end

        next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
